uart_axis_rx: RTL and testbench



---
 rtl/corescore_uart_pkg.sv | 17 +
 rtl/axis_fifo2.sv | 46 ++++
 rtl/uart_axis_rx.sv | 120 ++++++++++++
 tb/tb_uart_axis_rx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/corescore_uart_pkg.sv
// corescore_uart_pkg: shared UART receive types, divider helper and EOM default.
package corescore_uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;

    localparam logic [7:0] EOM_DEFAULT = 8'h0A;
    localparam int MIN_DIV = 8;

    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic bit div_ok(input int div);
        return div >= MIN_DIV;
    endfunction

endpackage

// File: rtl/axis_fifo2.sv
// axis_fifo2: 2-entry valid/ready buffer; a push while full with no pop is dropped.
module axis_fifo2 #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid,
    input  logic         ready,
    output logic         full,
    output logic         drop
);
    logic [1:0]   count;
    logic [W-1:0] head, tail;
    logic         pop, wr;

    assign valid = count != 2'd0;
    assign full  = count == 2'd2;
    assign pop   = valid && ready;
    assign wr    = push && (!full || pop);
    assign drop  = push && full && !pop;
    assign dout  = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (wr && !pop)
                count <= count + 2'd1;
            else if (pop && !wr)
                count <= count - 2'd1;
            // head takes the tail on a pop from full, otherwise the new byte when it becomes the head
            if (pop && full)
                head <= tail;
            else if (wr && (count == 2'd0 || pop))
                head <= din;
            if (wr && (full || (count == 2'd1 && !pop)))
                tail <= din;
        end
    end

endmodule

// File: rtl/uart_axis_rx.sv
// uart_axis_rx: 8N1 UART receiver feeding a 2-entry AXI-Stream byte buffer.
// Define UART_RX_PARITY_EN to expect an even-parity bit after bit 7 (8E1).
module uart_axis_rx
    import corescore_uart_pkg::*;
#(
    parameter int         CLK_FREQ = 16000000,
    parameter int         BAUD     = 57600,
    parameter logic [7:0] EOM_BYTE = EOM_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_uart_rx,
    output logic [7:0] o_tdata,
    output logic       o_tlast,
    output logic       o_tvalid,
    input  logic       i_tready,
    output logic       o_frame_err,
    output logic       o_overrun
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
`else
    localparam rx_state_t AFTER_DATA = STOP;
`endif

    if (!div_ok(DIV)) begin : g_div_check
        $error("uart_axis_rx: CLK_FREQ/BAUD must be at least 8");
    end

    logic [1:0]    sync;
    logic          rx_s, tick, push, buf_full;
    rx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    sh, sh_n;
    logic          par_err, par_err_n;

    assign rx_s = sync[1];
    assign tick = cnt == '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync    <= 2'b11;
            state   <= IDLE;
            cnt     <= '0;
            idx     <= 3'd0;
            sh      <= 8'd0;
            par_err <= 1'b0;
        end else begin
            sync    <= {sync[0], i_uart_rx};
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            sh      <= sh_n;
            par_err <= par_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = tick ? cnt : cnt - 1'b1;
        idx_n       = idx;
        sh_n        = sh;
        par_err_n   = par_err;
        push        = 1'b0;
        o_frame_err = 1'b0;
        case (state)
            IDLE: if (!rx_s) begin
                cnt_n   = HALF;
                state_n = START;
            end
            START: if (tick) begin
                if (rx_s)
                    state_n = IDLE;
                else begin
                    cnt_n     = FULL;
                    idx_n     = 3'd0;
                    par_err_n = 1'b0;
                    state_n   = DATA;
                end
            end
            DATA: if (tick) begin
                sh_n    = {rx_s, sh[7:1]};
                idx_n   = idx + 1'b1;
                cnt_n   = FULL;
                state_n = (idx == 3'd7) ? AFTER_DATA : DATA;
            end
            PARITY: if (tick) begin
                par_err_n = ^{rx_s, sh};
                cnt_n     = FULL;
                state_n   = STOP;
            end
            // a parity error with a good stop bit is reported here, without entering BREAK
            STOP: if (tick) begin
                push        = rx_s && !par_err;
                o_frame_err = !rx_s || par_err;
                state_n     = rx_s ? IDLE : BREAK;
            end
            BREAK: if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    axis_fifo2 #(.W(9)) u_buf (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (push),
        .din   ({sh == EOM_BYTE, sh}),
        .dout  ({o_tlast, o_tdata}),
        .valid (o_tvalid),
        .ready (i_tready),
        .full  (buf_full),
        .drop  (o_overrun)
    );

endmodule

// File: tb/tb_uart_axis_rx.sv
// tb_uart_axis_rx: table-driven and scoreboard bench for uart_axis_rx at DIV=16.
module tb_uart_axis_rx;
    localparam int CLK_FREQ = 921600;
    localparam int BAUD     = 57600;
    localparam int DIV      = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       i_clk = 1'b0, i_rst_n = 1'b0, i_uart_rx = 1'b1, i_tready = 1'b1;
    logic [7:0] o_tdata;
    logic       o_tlast, o_tvalid, o_frame_err, o_overrun;

    int checks = 0, errors = 0, ferr_cnt = 0, ovr_cnt = 0;
    logic [8:0] sb[$];

    typedef struct {
        logic [7:0] data;
        logic       tlast;
    } vec_t;
    vec_t vecs[7];

    uart_axis_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .EOM_BYTE(8'h0A)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_uart_rx   (i_uart_rx),
        .o_tdata     (o_tdata),
        .o_tlast     (o_tlast),
        .o_tvalid    (o_tvalid),
        .i_tready    (i_tready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (o_frame_err) ferr_cnt++;
        if (o_overrun) ovr_cnt++;
        if (o_tvalid && i_tready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat got %0h expected none", {o_tlast, o_tdata});
            end else
                check("beat", {23'd0, o_tlast, o_tdata}, {23'd0, sb.pop_front()});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic bit_out(input logic v);
        i_uart_rx = v;
        tick(DIV);
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input logic flip);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        if (PAR) bit_out(^b ^ flip);
        bit_out(stop);
    endtask

    task automatic idle(input int bits);
        i_uart_rx = 1'b1;
        tick(bits * DIV);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 8 * DIV) begin
            tick(1);
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f0, o0;
        vecs[0] = '{8'h55, 1'b0};
        vecs[1] = '{8'h48, 1'b0};
        vecs[2] = '{8'h0A, 1'b1};
        vecs[3] = '{8'h00, 1'b0};
        vecs[4] = '{8'hFF, 1'b0};
        vecs[5] = '{8'h80, 1'b0};
        vecs[6] = '{8'h0B, 1'b0};

        tick(3);
        check("rst_tvalid", o_tvalid, 0);
        check("rst_tdata", o_tdata, 0);
        check("rst_tlast", o_tlast, 0);
        check("rst_frame_err", o_frame_err, 0);
        check("rst_overrun", o_overrun, 0);
        i_rst_n = 1'b1;
        tick(3);

        // back-to-back frames, each beat compared by the monitor
        f0 = ferr_cnt;
        for (int i = 0; i < 7; i++) begin
            sb.push_back({vecs[i].tlast, vecs[i].data});
            send(vecs[i].data, 1'b1, 1'b0);
        end
        idle(1);
        wait_drain("table_drain");
        check("table_frame_err", ferr_cnt - f0, 0);

        // bad stop bit then line held low: one error, no beat, then recovery
        f0 = ferr_cnt;
        send(8'h33, 1'b0, 1'b0);
        tick(40 * DIV);
        idle(2);
        check("break_frame_err", ferr_cnt - f0, 1);
        check("break_no_beat", o_tvalid, 0);
        sb.push_back({1'b0, 8'h21});
        send(8'h21, 1'b1, 1'b0);
        idle(1);
        wait_drain("after_break_drain");

        // backpressure: third byte overruns the full buffer
        i_tready = 1'b0;
        o0 = ovr_cnt;
        sb.push_back({1'b0, 8'h01});
        sb.push_back({1'b0, 8'h02});
        send(8'h01, 1'b1, 1'b0);
        send(8'h02, 1'b1, 1'b0);
        send(8'h03, 1'b1, 1'b0);
        idle(1);
        check("overrun_count", ovr_cnt - o0, 1);
        check("stall_tvalid", o_tvalid, 1);
        check("stall_tdata", o_tdata, 8'h01);
        tick(5);
        check("stall_tdata_stable", o_tdata, 8'h01);
        i_tready = 1'b1;
        wait_drain("overrun_drain");
        tick(3 * DIV);
        check("overrun_no_extra", o_tvalid, 0);
        check("overrun_count_final", ovr_cnt - o0, 1);

        // short low glitch on idle line
        f0 = ferr_cnt;
        i_uart_rx = 1'b0;
        tick(DIV / 4);
        idle(3);
        check("glitch_frame_err", ferr_cnt - f0, 0);
        check("glitch_no_beat", o_tvalid, 0);

        // reset in the middle of a data phase
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        bit_out(1'b1);
        i_rst_n = 1'b0;
        tick(1);
        check("midrst_tvalid", o_tvalid, 0);
        check("midrst_frame_err", o_frame_err, 0);
        i_uart_rx = 1'b1;
        tick(2);
        i_rst_n = 1'b1;
        idle(2);
        f0 = ferr_cnt;
        sb.push_back({1'b0, 8'hA5});
        send(8'hA5, 1'b1, 1'b0);
        idle(1);
        wait_drain("after_reset_drain");
        check("after_reset_frame_err", ferr_cnt - f0, 0);

`ifdef UART_RX_PARITY_EN
        f0 = ferr_cnt;
        sb.push_back({1'b0, 8'h07});
        send(8'h07, 1'b1, 1'b0);
        idle(1);
        wait_drain("parity_good_drain");
        check("parity_good_err", ferr_cnt - f0, 0);
        send(8'h07, 1'b1, 1'b1);
        idle(2);
        check("parity_bad_err", ferr_cnt - f0, 1);
        check("parity_bad_no_beat", o_tvalid, 0);
`endif

        tick(4);
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
